fpga_config_loader: RTL and testbench

Synthesizable configuration controller for the `fpga` fabric top. It accepts configuration frames over a valid/ready stream and writes each frame into the fabric through `configs_in` with a one-hot `configs_en` write strobe. After the last frame it enables the fabric flip-flops (`ff_en`) and then raises `rdy`. It replaces the file-driven, testbench-only bitstream loading in per-design wrappers, and sits between a bitstream source (SPI/ROM/host FIFO) and the `fpga` instance.

---
 rtl/fpga_cfg_pkg.sv | 17 +
 rtl/cfg_settle_timer.sv | 33 +++
 rtl/fpga_config_loader.sv | 115 +++++++++++
 tb/tb_fpga_config_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared types and default sizes for the fabric configuration loader.
package fpga_cfg_pkg;

  localparam int CFG_W_DEF      = 320;
  localparam int NUM_FRAMES_DEF = 172;
  localparam int SETTLE_DEF     = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_SETTLE_FF,
    ST_SETTLE_RDY,
    ST_DONE
  } cfg_state_t;

endpackage

// File: rtl/cfg_settle_timer.sv
// Settle timer shared by both settle phases of the loader.
// While enabled it counts CYCLES cycles. On the last one it raises done
// and restarts from zero, so the next phase begins with a fresh count.
module cfg_settle_timer #(
  parameter int CYCLES = 10
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] count;

  assign done = enable && (count == CNT_W'(CYCLES - 1));

  // Count enabled cycles; restart on clear, reset or terminal count.
  always_ff @(posedge clock) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      if (done) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fpga_config_loader.sv
// Configuration controller for the fpga fabric.
// Frames arrive on a valid/ready stream. Each frame is written into the
// fabric with a one-cycle one-hot strobe. After the last frame the loader
// waits and raises ff_en, then waits again and raises rdy.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CFG_W         = CFG_W_DEF,
  parameter int NUM_FRAMES    = NUM_FRAMES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          cfg_valid,
  input  logic [CFG_W-1:0]              cfg_data,
  output logic                          cfg_ready,
  output logic [CFG_W-1:0]              configs_in,
  output logic [NUM_FRAMES-1:0]         configs_en,
  output logic                          ff_en,
  output logic                          rdy,
  output logic                          busy,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx
);

  localparam int IDX_W = $clog2(NUM_FRAMES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);
  localparam logic [NUM_FRAMES-1:0] EN_ONE = NUM_FRAMES'(1);

  cfg_state_t state;
  logic       timer_en;
  logic       timer_clear;
  logic       timer_done;

  // busy depends only on the state register, so no input reaches it combinationally.
  assign busy        = (state != ST_IDLE) && (state != ST_DONE);
  assign timer_en    = (state == ST_SETTLE_FF) || (state == ST_SETTLE_RDY);
  assign timer_clear = (state == ST_WRITE);

  cfg_settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clock  (clock),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .done   (timer_done)
  );

  // Main sequencer: state, stream handshake, frame strobe and completion flags.
  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= ST_IDLE;
      cfg_ready  <= 1'b0;
      configs_in <= '0;
      configs_en <= '0;
      ff_en      <= 1'b0;
      rdy        <= 1'b0;
      frame_idx  <= '0;
    end else begin
      configs_en <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            frame_idx <= '0;
            cfg_ready <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (cfg_valid && cfg_ready) begin
            configs_in <= cfg_data;
            configs_en <= EN_ONE << frame_idx;
            cfg_ready  <= 1'b0;
            state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (frame_idx == LAST_IDX) begin
            state <= ST_SETTLE_FF;
          end else begin
            frame_idx <= frame_idx + IDX_W'(1);
            cfg_ready <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_SETTLE_FF: begin
          if (timer_done) begin
            ff_en <= 1'b1;
            state <= ST_SETTLE_RDY;
          end
        end
        ST_SETTLE_RDY: begin
          if (timer_done) begin
            rdy   <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (start) begin
            ff_en     <= 1'b0;
            rdy       <= 1'b0;
            frame_idx <= '0;
            cfg_ready <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Bench for fpga_config_loader with a small geometry: 4 frames of 8 bits,
// and 3 settle cycles.
module tb_fpga_config_loader;

  localparam int CFG_W      = 8;
  localparam int NUM_FRAMES = 4;
  localparam int SETTLE     = 3;

  logic                  clock = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  cfg_valid;
  logic [CFG_W-1:0]      cfg_data;
  logic                  cfg_ready;
  logic [CFG_W-1:0]      configs_in;
  logic [NUM_FRAMES-1:0] configs_en;
  logic                  ff_en;
  logic                  rdy;
  logic                  busy;
  logic [1:0]            frame_idx;

  fpga_config_loader #(
    .CFG_W         (CFG_W),
    .NUM_FRAMES    (NUM_FRAMES),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .configs_in (configs_in),
    .configs_en (configs_en),
    .ff_en      (ff_en),
    .rdy        (rdy),
    .busy       (busy),
    .frame_idx  (frame_idx)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       ready;
    logic [3:0] en;
    logic [7:0] din;
    logic       ff;
    logic       rdy;
    logic       busy;
    logic [1:0] idx;
  } out_t;

  typedef struct packed {
    logic       start;
    logic       valid;
    logic       rst;
    logic [7:0] data;
    out_t       exp;
  } vec_t;

  int passed = 0;
  int total  = 0;

  // Reference model. The bitstream is tracked as "frames written so far".
  // The settle phases are timed by arithmetic from the cycle of the last strobe.
  int         cyc        = 0;
  bit         m_loading  = 1'b0;
  bit         m_strobe   = 1'b0;
  bit         m_finished = 1'b0;
  int         m_idx      = 0;
  int         m_last     = 0;
  logic [7:0] m_in       = 8'h00;
  out_t       m_exp;

  function automatic out_t mk(input logic ready, input logic [3:0] en, input logic [7:0] din,
                              input logic ff, input logic r, input logic b, input logic [1:0] idx);
    out_t o;
    o.ready = ready;
    o.en    = en;
    o.din   = din;
    o.ff    = ff;
    o.rdy   = r;
    o.busy  = b;
    o.idx   = idx;
    return o;
  endfunction

  function automatic vec_t row(input logic s, input logic v, input logic r, input logic [7:0] d,
                               input out_t e);
    vec_t x;
    x.start = s;
    x.valid = v;
    x.rst   = r;
    x.data  = d;
    x.exp   = e;
    return x;
  endfunction

  task automatic modelStep(input logic s, input logic v, input logic r, input logic [7:0] d);
    bit cur_rdy;
    cur_rdy = m_finished && (cyc >= m_last + 1 + 2 * SETTLE);
    if (r) begin
      m_loading  = 1'b0;
      m_strobe   = 1'b0;
      m_finished = 1'b0;
      m_idx      = 0;
      m_in       = 8'h00;
    end else if (m_loading) begin
      if (m_strobe) begin
        m_strobe = 1'b0;
        if (m_idx == NUM_FRAMES - 1) begin
          m_loading  = 1'b0;
          m_finished = 1'b1;
          m_last     = cyc;
        end else begin
          m_idx++;
        end
      end else if (v) begin
        m_strobe = 1'b1;
        m_in     = d;
      end
    end else if (!m_finished || cur_rdy) begin
      if (s) begin
        m_loading  = 1'b1;
        m_finished = 1'b0;
        m_strobe   = 1'b0;
        m_idx      = 0;
      end
    end
    cyc++;
    m_exp.ready = m_loading && !m_strobe;
    m_exp.en    = m_strobe ? (4'b0001 << m_idx) : 4'b0000;
    m_exp.din   = m_in;
    m_exp.ff    = m_finished && (cyc >= m_last + 1 + SETTLE);
    m_exp.rdy   = m_finished && (cyc >= m_last + 1 + 2 * SETTLE);
    m_exp.busy  = m_loading || (m_finished && !m_exp.rdy);
    m_exp.idx   = 2'(m_idx);
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic r, input logic [7:0] d);
    start     = s;
    cfg_valid = v;
    rst       = r;
    cfg_data  = d;
    @(posedge clock);
    modelStep(s, v, r, d);
    #1;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t act;
    act = mk(cfg_ready, configs_en, configs_in, ff_en, rdy, busy, frame_idx);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s @cyc %0d: got ready=%b en=%b in=%h ff=%b rdy=%b busy=%b idx=%0d, want ready=%b en=%b in=%h ff=%b rdy=%b busy=%b idx=%0d",
               name, cyc, act.ready, act.en, act.din, act.ff, act.rdy, act.busy, act.idx,
               exp.ready, exp.en, exp.din, exp.ff, exp.rdy, exp.busy, exp.idx);
    end
  endtask

  task automatic stepCheck(input string name, input logic s, input logic v, input logic r,
                           input logic [7:0] d);
    applyStimulus(s, v, r, d);
    checkOutput(name, m_exp);
  endtask

  vec_t tbl[19];
  out_t zero_out;

  initial begin
    zero_out = mk(1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);

    // Directed load with cfg_valid held high.
    tbl[0]  = row(0, 0, 1, 8'h00, mk(0, 4'b0000, 8'h00, 0, 0, 0, 0));
    tbl[1]  = row(1, 0, 0, 8'h00, mk(1, 4'b0000, 8'h00, 0, 0, 1, 0));
    tbl[2]  = row(0, 1, 0, 8'hA0, mk(0, 4'b0001, 8'hA0, 0, 0, 1, 0));
    tbl[3]  = row(0, 1, 0, 8'hA1, mk(1, 4'b0000, 8'hA0, 0, 0, 1, 1));
    tbl[4]  = row(0, 1, 0, 8'hA1, mk(0, 4'b0010, 8'hA1, 0, 0, 1, 1));
    tbl[5]  = row(0, 1, 0, 8'hA2, mk(1, 4'b0000, 8'hA1, 0, 0, 1, 2));
    tbl[6]  = row(0, 1, 0, 8'hA2, mk(0, 4'b0100, 8'hA2, 0, 0, 1, 2));
    tbl[7]  = row(0, 1, 0, 8'hA3, mk(1, 4'b0000, 8'hA2, 0, 0, 1, 3));
    tbl[8]  = row(0, 1, 0, 8'hA3, mk(0, 4'b1000, 8'hA3, 0, 0, 1, 3));
    tbl[9]  = row(0, 1, 0, 8'hA4, mk(0, 4'b0000, 8'hA3, 0, 0, 1, 3));
    tbl[10] = row(0, 1, 0, 8'hA4, mk(0, 4'b0000, 8'hA3, 0, 0, 1, 3));
    tbl[11] = row(0, 1, 0, 8'hA4, mk(0, 4'b0000, 8'hA3, 0, 0, 1, 3));
    tbl[12] = row(0, 1, 0, 8'hA4, mk(0, 4'b0000, 8'hA3, 1, 0, 1, 3));
    tbl[13] = row(0, 1, 0, 8'hA4, mk(0, 4'b0000, 8'hA3, 1, 0, 1, 3));
    tbl[14] = row(0, 1, 0, 8'hA4, mk(0, 4'b0000, 8'hA3, 1, 0, 1, 3));
    tbl[15] = row(0, 1, 0, 8'hA4, mk(0, 4'b0000, 8'hA3, 1, 1, 0, 3));
    tbl[16] = row(0, 1, 0, 8'hA4, mk(0, 4'b0000, 8'hA3, 1, 1, 0, 3));
    tbl[17] = row(1, 1, 0, 8'hA5, mk(1, 4'b0000, 8'hA3, 0, 0, 1, 0));
    tbl[18] = row(0, 1, 0, 8'hA5, mk(0, 4'b0001, 8'hA5, 0, 0, 1, 0));

    applyStimulus(0, 0, 1, 8'h00);
    applyStimulus(0, 0, 1, 8'h00);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i].start, tbl[i].valid, tbl[i].rst, tbl[i].data);
      checkOutput($sformatf("table_row%0d", i), tbl[i].exp);
    end

    // cfg_valid while idle must not be accepted.
    stepCheck("idle_reset", 0, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 8'h5A);
      checkOutput("idle_valid_ignored", zero_out);
    end

    // Reset after two strobes, then a clean restart from frame 0.
    stepCheck("rml_start", 1, 0, 0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      stepCheck("rml_load", 0, 1, 0, 8'h30 + 8'(k));
    end
    applyStimulus(0, 1, 1, 8'h00);
    checkOutput("rst_mid_load", zero_out);
    stepCheck("rml_restart", 1, 0, 0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      stepCheck("rml_reload", 0, 1, 0, 8'h40 + 8'(k));
    end

    // start pulses in LOAD and SETTLE_FF are ignored; start in DONE restarts.
    stepCheck("ign_reset", 0, 0, 1, 8'h00);
    stepCheck("ign_start", 1, 0, 0, 8'h00);
    for (int k = 0; k < 16; k++) begin
      stepCheck("ign_start_run", (k == 2 || k == 8), 1, 0, 8'h10 + 8'(k));
    end
    stepCheck("done_start", 1, 0, 0, 8'h00);
    stepCheck("done_restart_load", 0, 1, 0, 8'h77);

    // Randomized run with gaps, stray starts and occasional reset.
    for (int k = 0; k < 2500; k++) begin
      stepCheck("random",
                ($urandom % 16) == 0,
                ($urandom % 4) != 0,
                ($urandom % 200) == 0,
                8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
